// File: rtl/decoder.sv
// RV32I decode stage: one fetched word in, one registered decoder_output bundle out.
// Latency: 1 cycle from accept edge to decoder_valid; one-entry output register.
// Backpressure: decoder_ready drops while a held word is not consumed or a flush is active.
package decoder_pkg;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetcher_output;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] imm;
        logic        is_lui;
        logic        is_auipc;
        logic        is_jal;
        logic        is_jalr;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        is_alu_imm;
        logic        is_alu_reg;
        logic        is_fence;
        logic        is_system;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } decoder_output;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

module decoder
    import decoder_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          fetcher_valid,
    output logic          decoder_ready,
    input  fetcher_output in,
    input  logic          executor_ready,
    output logic          decoder_valid,
    input  logic          flush,
    output decoder_output out
);

    logic [31:0]   ins;
    logic [6:0]    opc;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic          legal;
    logic [31:0]   imm;
    decoder_output dec;

    assign ins = in.instr;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    always_comb begin
        legal = 1'b0;
        imm   = '0;
        case (opc)
            OP_LUI, OP_AUIPC: begin
                legal = 1'b1;
                imm   = {ins[31:12], 12'b0};
            end
            OP_JAL: begin
                legal = 1'b1;
                imm   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OP_JALR: begin
                legal = (f3 == 3'b000);
                imm   = {{20{ins[31]}}, ins[31:20]};
            end
            OP_BRANCH: begin
                legal = (f3[2:1] != 2'b01);
                imm   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OP_LOAD: begin
                legal = !(f3 == 3'b011 || f3[2:1] == 2'b11);
                imm   = {{20{ins[31]}}, ins[31:20]};
            end
            OP_STORE: begin
                legal = (f3 < 3'd3);
                imm   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OP_IMM: begin
                // Shift-immediates reuse funct7 as an opcode extension
                if (f3 == 3'b001)
                    legal = (f7 == 7'h00);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                else
                    legal = 1'b1;
                imm = {{20{ins[31]}}, ins[31:20]};
            end
            OP_REG: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OP_FENCE: begin
                legal = 1'b1;
                imm   = {{20{ins[31]}}, ins[31:20]};
            end
            OP_SYSTEM: begin
                legal = (ins == 32'h0000_0073) || (ins == 32'h0010_0073);
                imm   = {{20{ins[31]}}, ins[31:20]};
            end
            default: legal = 1'b0;
        endcase
        if (ins[1:0] != 2'b11 || ins == 32'h0000_0000 || ins == 32'hFFFF_FFFF)
            legal = 1'b0;
    end

    always_comb begin
        dec            = '0;
        dec.pc         = in.pc;
        dec.instr      = ins;
        dec.rd         = ins[11:7];
        dec.rs1        = ins[19:15];
        dec.rs2        = ins[24:20];
        dec.funct3     = f3;
        dec.funct7b5   = ins[30];
        dec.imm        = imm;
        dec.is_lui     = legal && (opc == OP_LUI);
        dec.is_auipc   = legal && (opc == OP_AUIPC);
        dec.is_jal     = legal && (opc == OP_JAL);
        dec.is_jalr    = legal && (opc == OP_JALR);
        dec.is_branch  = legal && (opc == OP_BRANCH);
        dec.is_load    = legal && (opc == OP_LOAD);
        dec.is_store   = legal && (opc == OP_STORE);
        dec.is_alu_imm = legal && (opc == OP_IMM);
        dec.is_alu_reg = legal && (opc == OP_REG);
        dec.is_fence   = legal && (opc == OP_FENCE);
        dec.is_system  = legal && (opc == OP_SYSTEM);
        dec.uses_rs1   = dec.is_jalr | dec.is_branch | dec.is_load | dec.is_store
                       | dec.is_alu_imm | dec.is_alu_reg;
        dec.uses_rs2   = dec.is_branch | dec.is_store | dec.is_alu_reg;
        dec.writes_rd  = (dec.is_lui | dec.is_auipc | dec.is_jal | dec.is_jalr | dec.is_load
                       | dec.is_alu_imm | dec.is_alu_reg) && (ins[11:7] != 5'd0);
        dec.illegal    = !legal;
    end

    assign decoder_ready = !reset && !flush && (!decoder_valid || executor_ready);

    // A word arriving while the held one is stalled is dropped; fetch never launches then
    always_ff @(posedge clk) begin
        if (reset) begin
            decoder_valid <= 1'b0;
            out           <= '0;
        end else if (flush) begin
            decoder_valid <= 1'b0;
        end else if (fetcher_valid && (!decoder_valid || executor_ready)) begin
            decoder_valid <= 1'b1;
            out           <= dec;
        end else if (decoder_valid && executor_ready) begin
            decoder_valid <= 1'b0;
        end
    end

`ifdef FORMAL
    logic          past_ok;
    logic          ready_q;
    logic          valid_q;
    logic          hold_q;
    logic          drop_ok_q;
    decoder_output out_q;

    always_ff @(posedge clk) begin
        past_ok   <= 1'b1;
        ready_q   <= decoder_ready;
        valid_q   <= decoder_valid;
        hold_q    <= decoder_valid && !executor_ready && !reset && !flush;
        drop_ok_q <= reset || flush || executor_ready;
        out_q     <= out;
    end

    always @(posedge clk) begin
        if (past_ok) begin
            assert (!(fetcher_valid && !ready_q));
            if (valid_q && !decoder_valid)
                assert (drop_ok_q);
            if (hold_q)
                assert (out == out_q);
        end
    end
`endif

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: directed vector table, hand-written handshake sequences,
// then randomized traffic against a queue-based reference model.
module tb_decoder;
    import decoder_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetcher_valid = 1'b0;
    logic          executor_ready = 1'b0;
    logic          flush = 1'b0;
    fetcher_output in = '0;
    logic          decoder_ready;
    logic          decoder_valid;
    decoder_output out;

    decoder dut (
        .clk(clk),
        .reset(reset),
        .fetcher_valid(fetcher_valid),
        .decoder_ready(decoder_ready),
        .in(in),
        .executor_ready(executor_ready),
        .decoder_valid(decoder_valid),
        .flush(flush),
        .out(out)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    decoder_output q[$];
    bit            zero_out = 1'b0;

    // Class indices: 0 lui 1 auipc 2 jal 3 jalr 4 branch 5 load 6 store 7 alu_imm 8 alu_reg 9 fence 10 system
    function automatic decoder_output ref_decode(logic [31:0] ins, logic [31:0] pc);
        decoder_output d;
        int  cls;
        bit  ok;
        int  op, f3, f7;
        int  s;
        d   = '0;
        op  = int'(ins & 32'h7F);
        f3  = int'((ins >> 12) & 7);
        f7  = int'(ins >> 25);
        s   = int'(ins);
        cls = -1;
        ok  = 1'b0;
        case (op)
            'h37: begin cls = 0;  ok = 1; end
            'h17: begin cls = 1;  ok = 1; end
            'h6F: begin cls = 2;  ok = 1; end
            'h67: begin cls = 3;  ok = (f3 == 0); end
            'h63: begin cls = 4;  ok = !(f3 == 2 || f3 == 3); end
            'h03: begin cls = 5;  ok = (f3 inside {0, 1, 2, 4, 5}); end
            'h23: begin cls = 6;  ok = (f3 <= 2); end
            'h13: begin cls = 7;  ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1; end
            'h33: begin cls = 8;  ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
            'h0F: begin cls = 9;  ok = 1; end
            'h73: begin cls = 10; ok = (ins == 32'h73) || (ins == 32'h0010_0073); end
            default: ok = 0;
        endcase
        d.pc       = pc;
        d.instr    = ins;
        d.rd       = 5'((ins >> 7) & 31);
        d.rs1      = 5'((ins >> 15) & 31);
        d.rs2      = 5'((ins >> 20) & 31);
        d.funct3   = 3'(f3);
        d.funct7b5 = ins[30];
        case (cls)
            0, 1:           d.imm = ins & 32'hFFFF_F000;
            2:              d.imm = 32'((ins[31] ? -(1 << 20) : 0) + int'((ins >> 12) & 255) * 4096
                                    + int'((ins >> 20) & 1) * 2048 + int'((ins >> 21) & 1023) * 2);
            4:              d.imm = 32'((ins[31] ? -4096 : 0) + int'((ins >> 7) & 1) * 2048
                                    + int'((ins >> 25) & 63) * 32 + int'((ins >> 8) & 15) * 2);
            6:              d.imm = 32'((s >>> 25) * 32 + int'((ins >> 7) & 31));
            3, 5, 7, 9, 10: d.imm = 32'(s >>> 20);
            default:        d.imm = '0;
        endcase
        if (!ok) begin
            d.illegal = 1'b1;
            return d;
        end
        d.is_lui     = (cls == 0);
        d.is_auipc   = (cls == 1);
        d.is_jal     = (cls == 2);
        d.is_jalr    = (cls == 3);
        d.is_branch  = (cls == 4);
        d.is_load    = (cls == 5);
        d.is_store   = (cls == 6);
        d.is_alu_imm = (cls == 7);
        d.is_alu_reg = (cls == 8);
        d.is_fence   = (cls == 9);
        d.is_system  = (cls == 10);
        d.uses_rs1   = (cls inside {3, 4, 5, 6, 7, 8});
        d.uses_rs2   = (cls inside {4, 6, 8});
        d.writes_rd  = (cls inside {0, 1, 2, 3, 5, 7, 8}) && (d.rd != 0);
        return d;
    endfunction

    // imm of an illegal word is not defined, so it is excluded from comparison
    function automatic decoder_output masked(decoder_output d);
        if (d.illegal) d.imm = '0;
        return d;
    endfunction

    task automatic chk_bit(string nm, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_vec(string nm, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_out(string nm, decoder_output act, decoder_output exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, check ready, advance model, then check outputs
    task automatic step(input bit rst, input bit fl, input bit er, input bit fv,
                        input logic [31:0] ins, input logic [31:0] pc);
        bit exp_rdy, can_take;
        reset          = rst;
        flush          = fl;
        executor_ready = er;
        fetcher_valid  = fv;
        in.instr       = ins;
        in.pc          = pc;
        #1;
        exp_rdy = !rst && !fl && (q.size() == 0 || er);
        chk_bit("ready", decoder_ready, exp_rdy);
        if (rst) begin
            q.delete();
            zero_out = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            can_take = (q.size() == 0) || er;
            if (q.size() != 0 && er) void'(q.pop_front());
            if (fv && can_take) begin
                q.push_back(ref_decode(ins, pc));
                zero_out = 1'b0;
            end
        end
        @(negedge clk);
        chk_bit("valid", decoder_valid, q.size() != 0);
        if (q.size() != 0)
            chk_out("out", masked(out), masked(q[0]));
        else if (zero_out)
            chk_out("out_zero", out, '0);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          ill;
        logic [10:0] cls;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  use_wr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        decoder_output held;
        logic [10:0]   cls_act;
        logic [31:0]   ins;
        bit            fv_prev;

        //          instr          pc          ill cls (lui..system)  rd  rs1 rs2 imm            uses1,uses2,wr
        tbl.push_back('{32'hFFF10093, 32'h100, 0, 11'b00000001000, 1,  2,  31, 32'hFFFFFFFF, 3'b101});
        tbl.push_back('{32'h00512423, 32'h104, 0, 11'b00000010000, 8,  2,  5,  32'h00000008, 3'b110});
        tbl.push_back('{32'hFE208EE3, 32'h108, 0, 11'b00001000000, 29, 1,  2,  32'hFFFFFFFC, 3'b110});
        tbl.push_back('{32'h123451B7, 32'h10C, 0, 11'b10000000000, 3,  8,  3,  32'h12345000, 3'b001});
        tbl.push_back('{32'h00000000, 32'h110, 1, 11'b00000000000, 0,  0,  0,  32'h0,        3'b000});
        tbl.push_back('{32'h02000033, 32'h114, 1, 11'b00000000000, 0,  0,  0,  32'h0,        3'b000});
        tbl.push_back('{32'h00002063, 32'h118, 1, 11'b00000000000, 0,  0,  0,  32'h0,        3'b000});
        tbl.push_back('{32'h0000006F, 32'h11C, 0, 11'b00100000000, 0,  0,  0,  32'h0,        3'b000});
        tbl.push_back('{32'h000280E7, 32'h120, 0, 11'b00010000000, 1,  5,  0,  32'h0,        3'b101});
        tbl.push_back('{32'h00100073, 32'h124, 0, 11'b00000000001, 0,  0,  1,  32'h00000001, 3'b000});
        tbl.push_back('{32'h402081B3, 32'h128, 0, 11'b00000000100, 3,  1,  2,  32'h0,        3'b111});
        tbl.push_back('{32'hFFFFFFFF, 32'h12C, 1, 11'b00000000000, 31, 31, 31, 32'h0,        3'b000});
        tbl.push_back('{32'h00001073, 32'h130, 1, 11'b00000000000, 0,  0,  0,  32'h0,        3'b000});
        tbl.push_back('{32'h6010D093, 32'h134, 1, 11'b00000000000, 1,  1,  1,  32'h0,        3'b000});
        tbl.push_back('{32'h00001297, 32'h138, 0, 11'b01000000000, 5,  0,  0,  32'h00001000, 3'b001});

        @(negedge clk);
        step(1, 0, 1, 0, 32'h0, 32'h0);
        step(1, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 1, 0, 32'h0, 32'h0);

        foreach (tbl[k]) begin
            step(0, 0, 1, 1, tbl[k].instr, tbl[k].pc);
            cls_act = {out.is_lui, out.is_auipc, out.is_jal, out.is_jalr, out.is_branch, out.is_load,
                       out.is_store, out.is_alu_imm, out.is_alu_reg, out.is_fence, out.is_system};
            chk_vec($sformatf("tbl%0d_fields", k),
                    {decoder_valid, out.illegal, cls_act, out.rd, out.rs1, out.rs2,
                     out.uses_rs1, out.uses_rs2, out.writes_rd, out.pc},
                    {1'b1, tbl[k].ill, tbl[k].cls, tbl[k].rd, tbl[k].rs1, tbl[k].rs2,
                     tbl[k].use_wr, tbl[k].pc});
            if (!tbl[k].ill)
                chk_vec($sformatf("tbl%0d_imm", k), out.imm, tbl[k].imm);
            step(0, 0, 1, 0, 32'h0, 32'h0);
        end

        // Stall for five cycles: output bit-stable, ready low; then release
        step(0, 0, 0, 1, 32'hFFF10093, 32'h200);
        held = out;
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 0, 32'h0, 32'h0);
            chk_out("hold_stable", out, held);
        end
        step(0, 0, 1, 0, 32'h0, 32'h0);
        chk_bit("hold_release_valid", decoder_valid, 1'b0);
        step(0, 0, 1, 0, 32'h0, 32'h0);

        // Flush with a held word while a new word arrives: both discarded
        step(0, 0, 0, 1, 32'h00512423, 32'h300);
        step(0, 1, 0, 1, 32'h123451B7, 32'h304);
        chk_bit("flush_valid", decoder_valid, 1'b0);
        step(0, 0, 1, 0, 32'h0, 32'h0);

        // Drain and accept on the same edge keeps valid high with the new word
        step(0, 0, 0, 1, 32'hFE208EE3, 32'h400);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 1, 32'h402081B3, 32'h408);
        chk_vec("swap_pc", out.pc, 32'h408);
        step(0, 0, 1, 0, 32'h0, 32'h0);

        // Reset while holding discards the word and zeroes outputs
        step(0, 0, 0, 1, 32'h00001297, 32'h500);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        fv_prev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit rst, fl, er, fv;
            int sel;
            logic [6:0] ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                    7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
            rst = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            er  = ($urandom_range(0, 2) != 0);
            fv  = !fv_prev && !rst && !fl && (q.size() == 0 || er) && ($urandom_range(0, 9) < 7);
            ins = $urandom;
            sel = $urandom_range(0, 13);
            if (sel < 11) begin
                ins[6:0] = ops[sel];
                if ($urandom_range(0, 1) == 1) ins[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
            end else if (sel == 11) begin
                ins = $urandom_range(0, 1) == 1 ? 32'h0000_0073 : 32'h0010_0073;
            end
            step(rst, fl, er, fv, ins, $urandom & 32'hFFFF_FFFC);
            fv_prev = fv;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder.md
# decoder

Second pipeline stage of the core. Accepts one fetched instruction word plus its PC per handshake from the fetch stage, decodes it as RV32I into a registered `decoder_output` bundle (register indices, sign-extended immediate, instruction-class flags, illegal flag), and holds it for the execute stage under a valid/ready handshake. Supports a single-cycle flush from execute on redirect (taken branch, jump, trap).

## Interface
Parameters: none.

- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  synchronous, active-high
- `fetcher_valid`  in  1  one-cycle pulse: `in` carries a new instruction
- `decoder_ready`  out  1  decoder can take an instruction launched at this edge
- `in`  in  `fetcher_output`  `{instr[31:0], pc[31:0]}`
- `executor_ready`  in  1  execute consumes `out` this cycle
- `decoder_valid`  out  1  `out` holds a decoded instruction
- `flush`  in  1  discard held and arriving instruction this cycle
- `out`  out  `decoder_output`  `pc, instr, rd, rs1, rs2 (5b each), funct3, funct7b5, imm[31:0], is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_alu_imm, is_alu_reg, is_fence, is_system, uses_rs1, uses_rs2, writes_rd, illegal`

## Operation
- `decoder_ready = !reset && !flush && (!decoder_valid || executor_ready)`; combinational from state and inputs.
- Contract: the fetch stage launches only at an edge where `decoder_ready` was 1 and presents `fetcher_valid` for exactly one cycle, never waiting. The decoder must therefore accept every `fetcher_valid` pulse not coinciding with `flush`; buffer is one entry, sufficient because the fetch stage never launches while its valid is high.
- Accept: `fetcher_valid && !flush` -> register decode of `in` into `out`, `decoder_valid <= 1`.
- Drain: `decoder_valid && executor_ready && !accept` -> `decoder_valid <= 0`.
- Hold: `decoder_valid && !executor_ready` -> `out` bit-stable. `fetcher_valid` cannot occur here (ready was 0 at launch); if it does, it is dropped and a `FORMAL` assertion fires.
- Flush: `decoder_valid <= 0`; `fetcher_valid` in the same cycle is dropped. Flush has priority over accept and hold.
- Decode rules:
  - `rd=instr[11:7]`, `rs1=instr[19:15]`, `rs2=instr[24:20]` always extracted.
  - imm by format: I `{{20{i[31]}},i[31:20]}`; S `{{20{i[31]}},i[31:25],i[11:7]}`; B `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],0}`; U `{i[31:12],12'b0}`; J `{{11{i[31]}},i[31],i[19:12],i[20],i[30:21],0}`; R: 0.
  - `uses_rs1`: jalr/branch/load/store/alu_imm/alu_reg.
  - `uses_rs2`: branch/store/alu_reg.
  - `writes_rd`: lui/auipc/jal/jalr/load/alu_imm/alu_reg and `rd != 0`.
  - Illegal: `instr[1:0] != 2'b11`; opcode outside RV32I; branch funct3 010/011; load funct3 011/110/111; store funct3 >= 011; jalr funct3 != 0; alu_imm shifts with bad funct7; alu_reg funct7 not 0x00/0x20 or 0x20 with funct3 not 000/101; system word not ECALL `0x00000073` / EBREAK `0x00100073`; all-zero and all-ones words.
  - Illegal instructions still pass through with `illegal=1` and every class, `uses_*` and `writes_rd` flag 0.

## Timing
- Reset: `decoder_valid=0`, every `out` field 0, `decoder_ready=0` while `reset` is high, 1 on the first cycle after.
- Latency: accept at edge N -> `decoder_valid=1` and `out` valid in cycle N+1.
- Throughput bounded by fetch: at most 1 instruction per 2 cycles.
- Simultaneous drain and accept: `out` takes the new word, `decoder_valid` stays 1.
- Reset mid-operation: held instruction discarded and outputs zeroed at that edge.
- `FORMAL`:
  - `decoder_valid` falls only via drain, flush or reset.
  - `out` is stable while `decoder_valid && !executor_ready`.
  - Never `fetcher_valid && !decoder_ready_at_launch`.

## Test plan
- After reset, `instr=0xFFF10093` (addi x1,x2,-1), `pc=0x100` -> next cycle `decoder_valid=1`, `is_alu_imm`, rd=1, rs1=2, imm=0xFFFFFFFF, `writes_rd=1`, pc=0x100.
- `0x00512423` (sw x5,8(x2)) -> `is_store`, rs1=2, rs2=5, imm=8, `uses_rs2=1`, `writes_rd=0`.
- `0xFE208EE3` (beq x1,x2,-4) -> `is_branch`, imm=0xFFFFFFFC; `0x123451B7` (lui x3,0x12345) -> imm=0x12345000, rd=3.
- `0x00000000`, `0x02000033` (funct7=1) and `0x00002063` (branch funct3 010) -> `illegal=1`, all class flags 0, still `decoder_valid=1`.
- `executor_ready=0` for 5 cycles with a held instruction -> `out` constant and `decoder_ready=0`; raise `executor_ready` -> valid drops next cycle, ready returns.
- Assert `flush` with a held instruction while `fetcher_valid` pulses -> both discarded, `decoder_valid=0` next cycle, `decoder_ready=0` during the flush cycle.
